// File: rtl/pixel_readout_ctrl.sv
// Column readout sequencer: freezes the column on a hit, steps the priority chain with READ
// pulses, captures {addr, ts_le, ts_te} per pixel into a valid/ready output word.
module pixel_readout_ctrl #(
  parameter int unsigned TS_DIV     = 4,
  parameter int unsigned SETTLE_CYC = 3,
  parameter int unsigned READ_CYC   = 2,
  parameter int unsigned MAX_HITS   = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_b,
  input  logic        i_en,
  input  logic        i_ts_rst,
  input  logic        i_hit_in,
  input  logic [7:0]  i_addr_out_b,
  input  logic [7:0]  i_ts_le_b,
  input  logic [7:0]  i_ts_te_b,
  output logic [7:0]  o_ts,
  output logic        o_freeze,
  output logic        o_read,
  output logic [23:0] o_dout,
  output logic        o_dout_valid,
  input  logic        i_dout_ready,
  output logic        o_busy,
  output logic [15:0] o_hit_cnt
);

  localparam int unsigned PW   = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int unsigned MAXC = (SETTLE_CYC > READ_CYC) ? SETTLE_CYC : READ_CYC;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int unsigned FW   = $clog2(MAX_HITS + 1);

  localparam logic [PW-1:0] PRESC_MAX   = PW'(TS_DIV - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] READ_LOAD   = CW'(READ_CYC - 1);
  localparam logic [FW-1:0] FRAME_MAX   = FW'(MAX_HITS);

  typedef enum logic [1:0] {StIdle, StSettle, StStall, StRead} state_e;

  state_e        r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_ts;
  logic          r_sync1;
  logic          r_hit_s;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_frame_hits;
  logic          r_freeze;
  logic          r_read;
  logic [23:0]   r_dout;
  logic          r_dout_valid;
  logic [15:0]   r_hit_cnt;

  logic w_accept;
  logic w_capture;
  logic w_out_free;

  assign w_accept   = r_dout_valid & i_dout_ready;
  assign w_capture  = (r_state == StRead) && (r_cnt == '0);
  // Output register can take a new word this cycle: empty or being drained.
  assign w_out_free = !r_dout_valid || i_dout_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_presc <= '0;
      r_ts    <= '0;
    end else if (i_ts_rst) begin
      r_presc <= '0;
      r_ts    <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_ts    <= r_ts + 8'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_sync1 <= 1'b0;
      r_hit_s <= 1'b0;
    end else begin
      r_sync1 <= i_hit_in;
      r_hit_s <= r_sync1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_frame_hits <= '0;
      r_freeze     <= 1'b0;
      r_read       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_hit_cnt    <= '0;
    end else begin
      // Capture wins over accept so a coincident drain keeps valid high with the new word.
      if (w_capture) begin
        r_dout       <= {~i_addr_out_b, i_ts_le_b, i_ts_te_b};
        r_dout_valid <= 1'b1;
      end else if (w_accept) begin
        r_dout_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          r_freeze <= 1'b0;
          r_read   <= 1'b0;
          if (i_en && r_hit_s) begin
            r_state      <= StSettle;
            r_freeze     <= 1'b1;
            r_cnt        <= SETTLE_LOAD;
            r_frame_hits <= '0;
          end
        end
        StSettle: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (!r_hit_s || (r_frame_hits == FRAME_MAX) || !i_en) begin
            r_state  <= StIdle;
            r_freeze <= 1'b0;
          end else if (!w_out_free) begin
            r_state <= StStall;
          end else begin
            r_state <= StRead;
            r_read  <= 1'b1;
            r_cnt   <= READ_LOAD;
          end
        end
        StStall: begin
          r_read <= 1'b0;
          if (w_out_free) begin
            r_state <= StRead;
            r_read  <= 1'b1;
            r_cnt   <= READ_LOAD;
          end
        end
        StRead: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_read       <= 1'b0;
            r_frame_hits <= r_frame_hits + FW'(1);
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            r_state <= StSettle;
            r_cnt   <= SETTLE_LOAD;
          end
        end
        default: begin
          r_state  <= StIdle;
          r_freeze <= 1'b0;
          r_read   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ts         = r_ts;
  assign o_freeze     = r_freeze;
  assign o_read       = r_read;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = (r_state != StIdle);
  assign o_hit_cnt    = r_hit_cnt;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl; a small pixel-chain model serves the address/TS buses.
module tb_pixel_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b, en, ts_rst, dout_ready;
  logic       man_hit;
  logic [7:0] man_addr_b, man_le, man_te;
  logic       model_on;
  int         pix_base, pix_num;
  int         pop_cnt = 0;
  logic       read_prev = 1'b0;
  logic [7:0] pix_addr_b [4];
  logic [7:0] pix_le     [4];
  logic [7:0] pix_te     [4];

  int         head;
  logic       hit_in;
  logic [7:0] addr_b, le_b, te_b;

  logic [7:0]  ts, m2_ts;
  logic        freeze, read, dout_valid, busy;
  logic        m2_freeze, m2_read, m2_dout_valid, m2_busy;
  logic [23:0] dout, m2_dout;
  logic [15:0] hit_cnt, m2_hit_cnt;

  int checks = 0;
  int errors = 0;

  // Pixel chain: HIT_IN high while pixels remain; the head pixel leaves when READ falls.
  always_comb begin
    head   = pop_cnt - pix_base;
    hit_in = man_hit;
    addr_b = man_addr_b;
    le_b   = man_le;
    te_b   = man_te;
    if (model_on) begin
      hit_in = (head >= 0) && (head < pix_num);
      addr_b = pix_addr_b[head[1:0]];
      le_b   = pix_le[head[1:0]];
      te_b   = pix_te[head[1:0]];
    end
  end

  always @(negedge clk) begin
    if (read_prev && !read) pop_cnt = pop_cnt + 1;
    read_prev = read;
  end

  pixel_readout_ctrl #(
    .TS_DIV(4), .SETTLE_CYC(3), .READ_CYC(2), .MAX_HITS(64)
  ) u_dut (
    .i_clk(clk), .i_rst_b(rst_b), .i_en(en), .i_ts_rst(ts_rst), .i_hit_in(hit_in),
    .i_addr_out_b(addr_b), .i_ts_le_b(le_b), .i_ts_te_b(te_b), .o_ts(ts),
    .o_freeze(freeze), .o_read(read), .o_dout(dout), .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready), .o_busy(busy), .o_hit_cnt(hit_cnt)
  );

  pixel_readout_ctrl #(
    .TS_DIV(4), .SETTLE_CYC(3), .READ_CYC(2), .MAX_HITS(2)
  ) u_max2 (
    .i_clk(clk), .i_rst_b(rst_b), .i_en(en), .i_ts_rst(ts_rst), .i_hit_in(hit_in),
    .i_addr_out_b(addr_b), .i_ts_le_b(le_b), .i_ts_te_b(te_b), .o_ts(m2_ts),
    .o_freeze(m2_freeze), .o_read(m2_read), .o_dout(m2_dout), .o_dout_valid(m2_dout_valid),
    .i_dout_ready(dout_ready), .o_busy(m2_busy), .o_hit_cnt(m2_hit_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    man_hit  = 1'b0;
    rst_b    = 1'b0;
    step(2);
    rst_b    = 1'b1;
  endtask

  initial begin
    rst_b = 1'b0; en = 1'b0; ts_rst = 1'b0; dout_ready = 1'b0;
    man_hit = 1'b0; man_addr_b = 8'hFF; man_le = 8'h00; man_te = 8'h00;
    model_on = 1'b0; pix_base = 0; pix_num = 0;
    for (int i = 0; i < 4; i++) begin
      pix_addr_b[i] = 8'hFF; pix_le[i] = 8'h00; pix_te[i] = 8'h00;
    end

    // Reset state
    step(2);
    chk("rst_ts", 32'(ts), 32'h0);
    chk("rst_freeze", 32'(freeze), 32'h0);
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hitcnt", 32'(hit_cnt), 32'h0);

    // Timestamp prescaler, wrap and clear-on-carry
    rst_b = 1'b1;
    chk("ts_t0", 32'(ts), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("ts_pre", 32'(ts), (i == 4) ? 32'h1 : 32'h0);
    end
    step(1019);
    chk("ts_ff", 32'(ts), 32'hFF);
    step(1);
    chk("ts_wrap", 32'(ts), 32'h00);
    step(7);
    chk("ts_1031", 32'(ts), 32'h01);
    ts_rst = 1'b1;
    step(1);
    chk("ts_rst_carry", 32'(ts), 32'h00);
    ts_rst = 1'b0;
    step(3);
    chk("ts_after_rst3", 32'(ts), 32'h00);
    step(1);
    chk("ts_after_rst4", 32'(ts), 32'h01);

    // Single pixel
    do_reset();
    en = 1'b1; dout_ready = 1'b1;
    pix_addr_b[0] = 8'hF5; pix_le[0] = 8'h12; pix_te[0] = 8'h34;
    pix_base = pop_cnt; pix_num = 1; model_on = 1'b1;
    step(2);
    chk("p1_freeze_e2", 32'(freeze), 32'h0);
    step(1);
    chk("p1_freeze_e3", 32'(freeze), 32'h1);
    chk("p1_busy_e3", 32'(busy), 32'h1);
    step(2);
    chk("p1_read_e5", 32'(read), 32'h0);
    step(1);
    chk("p1_read_e6", 32'(read), 32'h1);
    step(1);
    chk("p1_read_e7", 32'(read), 32'h1);
    step(1);
    chk("p1_read_e8", 32'(read), 32'h0);
    chk("p1_valid_e8", 32'(dout_valid), 32'h1);
    chk("p1_dout", 32'(dout), 32'h0A1234);
    chk("p1_hitcnt", 32'(hit_cnt), 32'h1);
    step(1);
    chk("p1_valid_e9", 32'(dout_valid), 32'h0);
    step(1);
    chk("p1_freeze_e10", 32'(freeze), 32'h1);
    step(1);
    chk("p1_freeze_e11", 32'(freeze), 32'h0);
    chk("p1_busy_e11", 32'(busy), 32'h0);

    // Three chained pixels with back-pressure on the first word
    do_reset();
    en = 1'b1; dout_ready = 1'b0;
    pix_addr_b[0] = 8'hFE; pix_le[0] = 8'h10; pix_te[0] = 8'h11;
    pix_addr_b[1] = 8'hFD; pix_le[1] = 8'h20; pix_te[1] = 8'h21;
    pix_addr_b[2] = 8'hFC; pix_le[2] = 8'h30; pix_te[2] = 8'h31;
    pix_base = pop_cnt; pix_num = 3; model_on = 1'b1;
    step(8);
    chk("p3_w1", 32'(dout), 32'h011011);
    chk("p3_w1_valid", 32'(dout_valid), 32'h1);
    step(3);
    chk("p3_stall_read", 32'(read), 32'h0);
    chk("p3_stall_busy", 32'(busy), 32'h1);
    step(2);
    chk("p3_stall_read2", 32'(read), 32'h0);
    chk("p3_hold_valid", 32'(dout_valid), 32'h1);
    chk("p3_hold_dout", 32'(dout), 32'h011011);
    dout_ready = 1'b1;
    step(1);
    chk("p3_read2_start", 32'(read), 32'h1);
    chk("p3_w1_drained", 32'(dout_valid), 32'h0);
    step(2);
    chk("p3_w2", 32'(dout), 32'h022021);
    chk("p3_w2_valid", 32'(dout_valid), 32'h1);
    chk("p3_cnt2", 32'(hit_cnt), 32'h2);
    step(3);
    chk("p3_read3_start", 32'(read), 32'h1);
    step(2);
    chk("p3_w3", 32'(dout), 32'h033031);
    chk("p3_cnt3", 32'(hit_cnt), 32'h3);
    step(3);
    chk("p3_freeze_end", 32'(freeze), 32'h0);
    chk("p3_busy_end", 32'(busy), 32'h0);

    // One-cycle HIT_IN glitch
    do_reset();
    en = 1'b1;
    man_hit = 1'b1;
    step(1);
    man_hit = 1'b0;
    step(1);
    chk("gl_freeze_e2", 32'(freeze), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("gl_freeze_hi", 32'(freeze), 32'h1);
      chk("gl_read_lo", 32'(read), 32'h0);
    end
    step(1);
    chk("gl_freeze_end", 32'(freeze), 32'h0);
    chk("gl_valid", 32'(dout_valid), 32'h0);
    chk("gl_busy", 32'(busy), 32'h0);

    // MAX_HITS=2 instance with HIT_IN held, then reset mid-READ
    do_reset();
    man_addr_b = 8'hF0; man_le = 8'h55; man_te = 8'hAA;
    man_hit = 1'b1; en = 1'b1; dout_ready = 1'b1;
    step(8);
    chk("mx_w1_valid", 32'(m2_dout_valid), 32'h1);
    chk("mx_w1", 32'(m2_dout), 32'h0F55AA);
    chk("mx_cnt1", 32'(m2_hit_cnt), 32'h1);
    step(5);
    chk("mx_cnt2", 32'(m2_hit_cnt), 32'h2);
    chk("mx_w2_valid", 32'(m2_dout_valid), 32'h1);
    step(3);
    chk("mx_freeze_drop", 32'(m2_freeze), 32'h0);
    chk("mx_busy_drop", 32'(m2_busy), 32'h0);
    step(1);
    chk("mx_refreeze", 32'(m2_freeze), 32'h1);
    step(3);
    chk("mx_read_again", 32'(m2_read), 32'h1);
    rst_b = 1'b0;
    step(1);
    chk("mx_rst_read", 32'(m2_read), 32'h0);
    chk("mx_rst_freeze", 32'(m2_freeze), 32'h0);
    chk("mx_rst_valid", 32'(m2_dout_valid), 32'h0);
    chk("mx_rst_cnt", 32'(m2_hit_cnt), 32'h0);
    rst_b = 1'b1;
    man_hit = 1'b0;

    // EN dropped during READ
    do_reset();
    en = 1'b1; dout_ready = 1'b1;
    pix_addr_b[0] = 8'hE0; pix_le[0] = 8'h41; pix_te[0] = 8'h42;
    pix_addr_b[1] = 8'hE1; pix_le[1] = 8'h51; pix_te[1] = 8'h52;
    pix_base = pop_cnt; pix_num = 2; model_on = 1'b1;
    step(6);
    chk("en_read_on", 32'(read), 32'h1);
    en = 1'b0;
    step(2);
    chk("en_w_valid", 32'(dout_valid), 32'h1);
    chk("en_w", 32'(dout), 32'h1F4142);
    chk("en_cnt", 32'(hit_cnt), 32'h1);
    step(2);
    chk("en_settle_freeze", 32'(freeze), 32'h1);
    chk("en_settle_read", 32'(read), 32'h0);
    step(1);
    chk("en_freeze_drop", 32'(freeze), 32'h0);
    chk("en_busy_drop", 32'(busy), 32'h0);
    step(5);
    chk("en_no_read", 32'(read), 32'h0);
    chk("en_no_freeze", 32'(freeze), 32'h0);
    chk("en_cnt_hold", 32'(hit_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
